// File: rtl/simd_wb_tracker.sv
// simd_wb_tracker
// Timing wheel that schedules SIMD writebacks a fixed number of cycles after
// issue. It exposes the writeback slot for the current cycle, a mask of vector
// registers that still have a writeback pending, the number of in-flight
// entries, and a sticky error flag for double-booked slots or illegal latencies.
//
// Handshake: issue_valid_i is a single-cycle qualifier with no back-pressure.
// The tracker samples it on every rising clk_i edge. When issue_valid_i is high,
// issue_stages_i, issue_vd_i and issue_gl_idx_i must be stable in that cycle.
// wb_valid_o is a single-cycle pulse, and wb_vd_o/wb_gl_idx_o are meaningful only
// while it is high. Nothing downstream can stall a writeback.
module simd_wb_tracker #(
  parameter int NUM_SLOTS = 32,
  parameter int VREG_W    = 5,
  parameter int GL_IDX_W  = 5
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   issue_valid_i,
  input  logic [5:0]             issue_stages_i,
  input  logic [VREG_W-1:0]      issue_vd_i,
  input  logic [GL_IDX_W-1:0]    issue_gl_idx_i,
  output logic                   wb_valid_o,
  output logic [VREG_W-1:0]      wb_vd_o,
  output logic [GL_IDX_W-1:0]    wb_gl_idx_o,
  output logic [(2**VREG_W)-1:0] pending_vd_o,
  output logic [5:0]             inflight_cnt_o,
  output logic                   collision_o
);

  localparam int PTR_W = $clog2(NUM_SLOTS);

  // Wheel storage: one entry per future cycle, indexed relative to ptr_q.
  logic [NUM_SLOTS-1:0] slot_valid_q;
  logic [VREG_W-1:0]    slot_vd_q [NUM_SLOTS];
  logic [GL_IDX_W-1:0]  slot_gl_q [NUM_SLOTS];
  logic [PTR_W-1:0]     ptr_q;

  logic                 wb_valid_q;
  logic [VREG_W-1:0]    wb_vd_q;
  logic [GL_IDX_W-1:0]  wb_gl_q;
  logic [5:0]           inflight_cnt_q;
  logic                 collision_q;

  logic [7:0]           target_sum;
  logic [PTR_W-1:0]     target;
  logic                 stages_legal;
  logic                 slot_busy;
  logic                 issue_live;
  logic                 accept;
  logic                 bypass;
  logic                 schedule;
  logic [5:0]           cnt_next;

  // Issue decode: the target slot, legality, collision detection, and the bypass/schedule split.
  always_comb begin
    target_sum   = 8'(ptr_q) + 8'(issue_stages_i) - 8'd1;
    target       = target_sum[PTR_W-1:0];
    stages_legal = (issue_stages_i != 6'd0) && (7'(issue_stages_i) <= 7'(NUM_SLOTS));
    slot_busy    = slot_valid_q[target];
    issue_live   = issue_valid_i & ~flush_i;
    // Dropping on collision keeps the older entry untouched.
    accept       = issue_live & stages_legal & ~slot_busy;
    // With N=1 the target is the slot being popped now, so go straight to the output.
    bypass       = accept & (target == ptr_q);
    schedule     = accept & ~bypass;
    cnt_next     = inflight_cnt_q + {5'd0, accept} - {5'd0, wb_valid_q};
  end

  // Wheel update: pop the current slot into the wb registers, insert new issues, and advance the pointer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_vd_q[i] <= '0;
        slot_gl_q[i] <= '0;
      end
      ptr_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_vd_q        <= '0;
      wb_gl_q        <= '0;
      inflight_cnt_q <= '0;
      collision_q    <= 1'b0;
    end else begin
      ptr_q       <= ptr_q + PTR_W'(1);
      collision_q <= collision_q | (issue_live & (~stages_legal | slot_busy));
      if (flush_i) begin
        slot_valid_q   <= '0;
        wb_valid_q     <= 1'b0;
        wb_vd_q        <= '0;
        wb_gl_q        <= '0;
        inflight_cnt_q <= '0;
      end else begin
        slot_valid_q[ptr_q] <= 1'b0;
        // A scheduled target never equals ptr_q, so this cannot clash with the pop above.
        if (schedule) begin
          slot_valid_q[target] <= 1'b1;
          slot_vd_q[target]    <= issue_vd_i;
          slot_gl_q[target]    <= issue_gl_idx_i;
        end
        if (bypass) begin
          wb_valid_q <= 1'b1;
          wb_vd_q    <= issue_vd_i;
          wb_gl_q    <= issue_gl_idx_i;
        end else if (slot_valid_q[ptr_q]) begin
          wb_valid_q <= 1'b1;
          wb_vd_q    <= slot_vd_q[ptr_q];
          wb_gl_q    <= slot_gl_q[ptr_q];
        end else begin
          wb_valid_q <= 1'b0;
          wb_vd_q    <= '0;
          wb_gl_q    <= '0;
        end
        inflight_cnt_q <= cnt_next;
      end
    end
  end

  // Pending mask: OR-decode of every valid wheel entry plus the writeback now on the output.
  always_comb begin
    pending_vd_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_valid_q[i]) pending_vd_o[slot_vd_q[i]] = 1'b1;
    end
    if (wb_valid_q) pending_vd_o[wb_vd_q] = 1'b1;
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_vd_o        = wb_vd_q;
  assign wb_gl_idx_o    = wb_gl_q;
  assign inflight_cnt_o = inflight_cnt_q;
  assign collision_o    = collision_q;

endmodule
